// File: rtl/bubble_sort_ctrl_if.sv
// ============================================================================
// Module   : bubble_sort_ctrl_if
// Brief    : valid/ready vector stream carrying one DATA_N x DATA_W vector
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bubble_sort_ctrl_if #(
  parameter int DATA_N = 4,
  parameter int DATA_W = 4
);
  logic                       valid;
  logic                       ready;
  logic [DATA_N*DATA_W-1:0]   data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

`default_nettype wire

// File: rtl/bubble_sort_ctrl.sv
// ============================================================================
// Module   : bubble_sort_ctrl
// Brief    : credit-based scheduler around a descending odd-even sorter with
//            an output FIFO and a drain/flush handshake
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bubble_sort_ctrl #(
  parameter int DATA_N     = 4,
  parameter int DATA_W     = 4,
  parameter int PIPE_EN    = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  bubble_sort_ctrl_if.slave                 s_if,
  bubble_sort_ctrl_if.master                m_if,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              busy,
  output logic [$clog2(OBUF_DEPTH+1)-1:0]   occupancy
);

  localparam int VEC_W    = DATA_N * DATA_W;
  localparam int SORT_LAT = (PIPE_EN != 0) ? DATA_N - 2 : 0;
  localparam int OCC_W    = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W    = $clog2(OBUF_DEPTH);
  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(OBUF_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_flush_done;
  logic              w_s_ready;
  logic              w_m_valid;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [VEC_W-1:0]  w_sorted;
  logic [OCC_W-1:0]  w_inflight;
  logic [OCC_W-1:0]  w_occupancy;
  logic [OCC_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [VEC_W-1:0]  r_mem [OBUF_DEPTH];

  // One odd-even transposition pass; larger element moves to the lower index.
  function automatic logic [VEC_W-1:0] f_pass(input logic [VEC_W-1:0] v, input int parity);
    logic [VEC_W-1:0]  res;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    res = v;
    for (int i = 0; i < DATA_N - 1; i++) begin
      if ((i % 2) == parity) begin
        a = v[i*DATA_W +: DATA_W];
        b = v[(i+1)*DATA_W +: DATA_W];
        if (a < b) begin
          res[i*DATA_W +: DATA_W]     = b;
          res[(i+1)*DATA_W +: DATA_W] = a;
        end
      end
    end
    return res;
  endfunction

  // Credit uses registered counts only, so a pop frees a slot one cycle later.
  assign w_occupancy = w_inflight + r_count;
  assign w_s_ready   = rst_n && (r_state == ST_RUN) && (w_occupancy < C_DEPTH);
  assign w_accept    = s_if.valid && w_s_ready;
  assign w_m_valid   = (r_count != '0);
  assign w_pop       = w_m_valid && m_if.ready;

  assign s_if.ready  = w_s_ready;
  assign m_if.valid  = w_m_valid;
  assign m_if.data   = r_mem[r_rd_ptr];
  assign occupancy   = w_occupancy;
  assign busy        = (w_inflight != '0) || (r_count != '0);
  assign flush_done  = r_flush_done;

  // N passes in total: the first segment does two passes, each later segment
  // one, and the last pass sits combinationally after the final register.
  generate
    if (SORT_LAT > 0) begin : g_sort_pipe
      logic [VEC_W-1:0] w_seg [SORT_LAT];
      logic [VEC_W-1:0] r_seg [SORT_LAT];

      always_comb begin
        for (int j = 0; j < SORT_LAT; j++) begin
          w_seg[j] = '0;
        end
        w_seg[0] = f_pass(f_pass(s_if.data, 0), 1);
        for (int j = 1; j < SORT_LAT; j++) begin
          w_seg[j] = f_pass(r_seg[j-1], (j + 1) % 2);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int j = 0; j < SORT_LAT; j++) begin
            r_seg[j] <= '0;
          end
        end else begin
          for (int j = 0; j < SORT_LAT; j++) begin
            r_seg[j] <= w_seg[j];
          end
        end
      end

      assign w_sorted = f_pass(r_seg[SORT_LAT-1], (DATA_N - 1) % 2);
    end else begin : g_sort_comb
      always_comb begin
        w_sorted = s_if.data;
        for (int p = 0; p < DATA_N; p++) begin
          w_sorted = f_pass(w_sorted, p % 2);
        end
      end
    end
  endgenerate

  generate
    if (SORT_LAT > 0) begin : g_chain
      logic [SORT_LAT-1:0] r_chain;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_chain <= '0;
        end else begin
          r_chain <= (r_chain << 1) | SORT_LAT'(w_accept);
        end
      end

      assign w_push = r_chain[SORT_LAT-1];

      always_comb begin
        w_inflight = '0;
        for (int i = 0; i < SORT_LAT; i++) begin
          w_inflight = w_inflight + OCC_W'(r_chain[i]);
        end
      end
    end else begin : g_no_chain
      assign w_push     = w_accept;
      assign w_inflight = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sorted;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (flush_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_occupancy == '0) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == C_DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_bubble_sort_ctrl.sv
// ============================================================================
// Module   : tb_bubble_sort_ctrl
// Brief    : directed self-checking bench for bubble_sort_ctrl (4x4b, depth 4)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bubble_sort_ctrl;

  localparam int DATA_N     = 4;
  localparam int DATA_W     = 4;
  localparam int OBUF_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_req = 1'b0;
  logic       flush_done;
  logic       busy;
  logic [2:0] occupancy;

  bubble_sort_ctrl_if #(.DATA_N(DATA_N), .DATA_W(DATA_W)) s_if ();
  bubble_sort_ctrl_if #(.DATA_N(DATA_N), .DATA_W(DATA_W)) m_if ();

  bubble_sort_ctrl #(
    .DATA_N     (DATA_N),
    .DATA_W     (DATA_W),
    .PIPE_EN    (1),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_if       (s_if),
    .m_if       (m_if),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .busy       (busy),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int out_cnt  = 0;
  int fd_cnt   = 0;
  int fd_cyc   = 0;
  int last_pop_cyc = 0;
  int pop_cyc_q [$];
  logic [15:0] exp_q [$];

  // Inputs elem0..3 packed {e3,e2,e1,e0}; expected outputs descending.
  logic [15:0] in_tab  [8] = '{16'h4321, 16'h1234, 16'h0F0F, 16'h7777,
                               16'h9000, 16'h15A5, 16'h8682, 16'h0E3C};
  logic [15:0] out_tab [8] = '{16'h1234, 16'h1234, 16'h00FF, 16'h7777,
                               16'h0009, 16'h155A, 16'h2688, 16'h03CE};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outs(input int target, input int budget);
    int n;
    n = 0;
    while (out_cnt < target && n < budget) begin
      step();
      n++;
    end
    check_eq("wait_outs", out_cnt, target);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_if.valid && m_if.ready) begin
      check_eq("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_eq("m_data", m_if.data, exp_q.pop_front());
      end
      out_cnt++;
      last_pop_cyc = cyc;
      pop_cyc_q.push_back(cyc);
    end
    if (flush_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int idx;
    int n;
    logic stale;

    s_if.valid  = 1'b0;
    s_if.data   = '0;
    m_if.ready  = 1'b0;

    // Reset state
    step();
    step();
    check_eq("rst_s_ready", s_if.ready, 0);
    check_eq("rst_m_valid", m_if.valid, 0);
    check_eq("rst_m_data", m_if.data, 0);
    check_eq("rst_flush_done", flush_done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_occupancy", occupancy, 0);
    rst_n = 1'b1;
    step();

    // Single vector [3,1,4,2] -> [4,3,2,1]
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 16'h2413;
    check_eq("single_s_ready", s_if.ready, 1);
    exp_q.push_back(16'h1234);
    step();
    s_if.valid = 1'b0;
    check_eq("single_occ", occupancy, 1);
    check_eq("single_busy", busy, 1);
    lat = 1;
    while (!m_if.valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq("single_latency", lat, 3);
    wait_outs(1, 10);
    step();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_occ", occupancy, 0);

    // Eight back-to-back vectors at full throughput
    base = out_cnt;
    for (int i = 0; i < 8; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = in_tab[i];
      check_eq("stream_s_ready", s_if.ready, 1);
      exp_q.push_back(out_tab[i]);
      step();
    end
    s_if.valid = 1'b0;
    wait_outs(base + 8, 30);
    if (pop_cyc_q.size() >= base + 8) begin
      check_eq("stream_span", pop_cyc_q[base+7] - pop_cyc_q[base], 7);
    end

    // Backpressure: credits stop admission at exactly OBUF_DEPTH
    m_if.ready = 1'b0;
    base = out_cnt;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      s_if.valid = 1'b1;
      s_if.data  = in_tab[idx % 8];
      if (s_if.ready) begin
        exp_q.push_back(out_tab[idx % 8]);
        idx++;
      end
      step();
    end
    s_if.valid = 1'b0;
    check_eq("bp_accepted", idx, 4);
    check_eq("bp_s_ready", s_if.ready, 0);
    check_eq("bp_occ", occupancy, 4);
    check_eq("bp_m_valid", m_if.valid, 1);
    m_if.ready = 1'b1;
    check_eq("bp_no_bypass", s_if.ready, 0);
    step();
    check_eq("bp_credit_back", s_if.ready, 1);
    wait_outs(base + 4, 20);

    // Flush with buffered data; flush_req coincides with the third handshake
    m_if.ready = 1'b0;
    base = out_cnt;
    fd_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      s_if.valid = 1'b1;
      s_if.data  = in_tab[4+k];
      flush_req  = (k == 2);
      check_eq("flush_fill_ready", s_if.ready, 1);
      exp_q.push_back(out_tab[4+k]);
      step();
    end
    s_if.valid = 1'b0;
    flush_req  = 1'b0;
    check_eq("flush_s_ready", s_if.ready, 0);
    repeat (9) step();
    check_eq("flush_no_early_done", fd_cnt, 0);
    check_eq("flush_occ", occupancy, 3);
    check_eq("flush_hold_ready", s_if.ready, 0);
    m_if.ready = 1'b1;
    wait_outs(base + 3, 20);
    n = 0;
    while (fd_cnt == 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("flush_done_cnt", fd_cnt, 1);
    check_eq("flush_done_delay", fd_cyc - last_pop_cyc, 2);
    check_eq("flush_run_ready", s_if.ready, 1);
    step();
    check_eq("flush_done_width", fd_cnt, 1);

    // Flush while empty: RUN -> DRAIN -> DONE
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check_eq("eflush_drain_ready", s_if.ready, 0);
    check_eq("eflush_drain_done", flush_done, 0);
    step();
    check_eq("eflush_done", flush_done, 1);
    check_eq("eflush_done_ready", s_if.ready, 0);
    step();
    check_eq("eflush_after_done", flush_done, 0);
    check_eq("eflush_after_ready", s_if.ready, 1);

    // Reset mid-operation with two in flight and two buffered
    m_if.ready = 1'b0;
    base = out_cnt;
    for (int k = 0; k < 4; k++) begin
      s_if.valid = 1'b1;
      s_if.data  = in_tab[k];
      check_eq("mrst_fill_ready", s_if.ready, 1);
      step();
    end
    s_if.valid = 1'b0;
    check_eq("mrst_occ_before", occupancy, 4);
    check_eq("mrst_busy_before", busy, 1);
    rst_n = 1'b0;
    step();
    check_eq("mrst_s_ready", s_if.ready, 0);
    rst_n = 1'b1;
    check_eq("mrst_m_valid", m_if.valid, 0);
    check_eq("mrst_m_data", m_if.data, 0);
    check_eq("mrst_occ", occupancy, 0);
    check_eq("mrst_busy", busy, 0);
    m_if.ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      step();
      stale = stale | m_if.valid;
    end
    check_eq("mrst_no_stale", stale, 0);
    check_eq("mrst_no_output", out_cnt, base);

    check_eq("total_outputs", out_cnt, 16);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
